// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way tie-break: on a tie the requester not served last wins,
// otherwise the lone requester wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_o
);

    always_comb begin
        win_o = REQ_CPU;
        if (req_i[0] && req_i[1]) begin
            win_o = ~last_i;
        end else if (req_i[1]) begin
            win_o = REQ_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU (r0) and DMA/debug (r1) onto one memory port, one access per 3 cycles.
// Define MEM_ARB_FIXED_PRIO_EN to give ties to requester 0 instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r1_req,
    input  logic          r0_we,
    input  logic          r1_we,
    input  logic          r0_byte,
    input  logic          r1_byte,
    input  logic [31:0]   r0_addr,
    input  logic [31:0]   r1_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [DW-1:0] r1_wdata,
    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_rvalid,
    output logic          r1_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic [DW-1:0] r1_rdata,
    output logic          m_we,
    output logic          m_byte,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    arb_state_e state_q;
    logic       owner_q;
    logic       rd_q;
    logic       last_srv;
    logic       win_d;

    logic          sel_we;
    logic          sel_byte;
    logic [31:0]   sel_addr;
    logic [DW-1:0] sel_wdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{r0_addr[31:AW], r1_addr[31:AW]};

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Pretending requester 1 was always served last hands every tie to requester 0.
    assign last_srv = REQ_DMA;
`else
    logic last_q;
    assign last_srv = last_q;
`endif

    rr_arb2 u_rr_arb2 (
        .req_i  ({r1_req, r0_req}),
        .last_i (last_srv),
        .win_o  (win_d)
    );

    assign sel_we    = (win_d == REQ_DMA) ? r1_we    : r0_we;
    assign sel_byte  = (win_d == REQ_DMA) ? r1_byte  : r0_byte;
    assign sel_addr  = (win_d == REQ_DMA) ? r1_addr  : r0_addr;
    assign sel_wdata = (win_d == REQ_DMA) ? r1_wdata : r0_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= REQ_CPU;
            rd_q      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q    <= REQ_DMA;
`endif
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            m_we      <= 1'b0;
            m_byte    <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
        end else begin
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        state_q <= ACCESS;
                        owner_q <= win_d;
                        rd_q    <= ~sel_we;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_q  <= win_d;
`endif
                        r0_gnt  <= (win_d == REQ_CPU);
                        r1_gnt  <= (win_d == REQ_DMA);
                        m_we    <= sel_we;
                        // Byte writes are unsupported, so a write always goes out as a word.
                        m_byte  <= sel_we ? 1'b0 : sel_byte;
                        m_addr  <= sel_addr[AW-1:0];
                        m_wdata <= sel_wdata;
                    end
                end
                ACCESS: begin
                    state_q <= RESP;
                    m_we    <= 1'b0;
                    if (rd_q) begin
                        if (owner_q == REQ_DMA) begin
                            r1_rdata  <= m_rdata;
                            r1_rvalid <= 1'b1;
                        end else begin
                            r0_rdata  <= m_rdata;
                            r0_rvalid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    m_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a byte-addressed memory model on the m_* port.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_req, r1_req, r0_we, r1_we, r0_byte, r1_byte;
    logic [31:0]   r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          m_we, m_byte;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r1_req(r1_req),
        .r0_we(r0_we), .r1_we(r1_we),
        .r0_byte(r0_byte), .r1_byte(r1_byte),
        .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .m_we(m_we), .m_byte(m_byte), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int wrap(input int a, input int k);
        return (a + k) % 1024;
    endfunction

    // Memory model: read data presented on negedge, writes land on posedge.
    always @(negedge clk) begin
        if (m_byte) m_rdata <= {24'h0, mem[int'(m_addr)]};
        else        m_rdata <= {mem[wrap(int'(m_addr), 3)], mem[wrap(int'(m_addr), 2)],
                                mem[wrap(int'(m_addr), 1)], mem[int'(m_addr)]};
    end

    always @(posedge clk) begin
        if (m_we) begin
            for (int k = 0; k < 4; k++) mem[wrap(int'(m_addr), k)] <= m_wdata[8*k +: 8];
        end
    end

    function automatic logic [31:0] ref_rd(input logic [31:0] addr, input logic bt);
        int a;
        a = int'(addr[AW-1:0]);
        if (bt) return {24'h0, ref_mem[a]};
        return {ref_mem[wrap(a, 3)], ref_mem[wrap(a, 2)], ref_mem[wrap(a, 1)], ref_mem[a]};
    endfunction

    task automatic ref_wr(input logic [31:0] addr, input logic [31:0] d);
        int a;
        a = int'(addr[AW-1:0]);
        for (int k = 0; k < 4; k++) ref_mem[wrap(a, k)] = d[8*k +: 8];
    endtask

    // Protocol monitor and scoreboard pop.
    always @(negedge clk) begin
        exp_t e;
        if (r0_gnt || r1_gnt) chk("one_gnt", 64'(r0_gnt & r1_gnt), 64'd0);
        if (m_we) chk("m_we_only_access", 64'(r0_gnt | r1_gnt), 64'd1);
        if (r0_rvalid || r1_rvalid) begin
            chk("one_rvalid", 64'(r0_rvalid & r1_rvalid), 64'd0);
            chk("rvalid_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rvalid_id", 64'(r1_rvalid), 64'(e.id));
                chk("rdata", 64'(r1_rvalid ? r1_rdata : r0_rdata), 64'(e.data));
            end
        end
    end

    task automatic do_req(input logic id, input logic we, input logic bt,
                          input logic [31:0] addr, input logic [31:0] wd, output int gcyc);
        logic got;
        exp_t e;
        if (id) begin
            r1_req = 1'b1; r1_we = we; r1_byte = bt; r1_addr = addr; r1_wdata = wd;
        end else begin
            r0_req = 1'b1; r0_we = we; r0_byte = bt; r0_addr = addr; r0_wdata = wd;
        end
        if (we) begin
            ref_wr(addr, wd);
        end else begin
            e.id   = id;
            e.data = ref_rd(addr, bt);
            exp_q.push_back(e);
        end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = id ? r1_gnt : r0_gnt;
        end
        chk("gnt_seen", 64'(got), 64'd1);
        gcyc = cyc;
        if (got) begin
            chk("m_we", 64'(m_we), 64'(we));
            chk("m_addr", 64'(m_addr), 64'(addr[AW-1:0]));
            chk("m_byte", 64'(m_byte), 64'(we ? 1'b0 : bt));
            if (we) chk("m_wdata", 64'(m_wdata), 64'(wd));
        end
        if (id) r1_req = 1'b0;
        else    r0_req = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int   g0, g1, g, start, prev;
        logic got, ek, seen;

        rst = 1'b0;
        r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0; r0_byte = 0; r1_byte = 0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
        repeat (2) @(negedge clk);

        chk("rst_gnt", 64'({r0_gnt, r1_gnt}), 64'd0);
        chk("rst_rvalid", 64'({r0_rvalid, r1_rvalid}), 64'd0);
        chk("rst_m_we", 64'(m_we), 64'd0);
        chk("rst_m_byte", 64'(m_byte), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_wdata", 64'(m_wdata), 64'd0);
        chk("rst_rdata", {r0_rdata, r1_rdata}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Word write then word read by r0.
        do_req(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, g);
        wait_drain();
        do_req(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, g);
        wait_drain();
        chk("r0_rdata_word", 64'(r0_rdata), 64'hDEADBEEF);

        // r1 byte read must not disturb r0.
        do_req(1'b1, 1'b0, 1'b1, 32'h11, 32'h0, g);
        wait_drain();
        chk("r1_rdata_byte", 64'(r1_rdata), 64'hBE);
        chk("r0_rdata_kept", 64'(r0_rdata), 64'hDEADBEEF);

        // Byte flag on a write is ignored; full word lands.
        do_req(1'b1, 1'b1, 1'b1, 32'h40, 32'h11223344, g);
        wait_drain();
        do_req(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, g);
        wait_drain();

        // Tie: both held high for four grants from a fresh reset.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        r0_we = 1; r0_byte = 0; r0_addr = 32'h20; r0_wdata = 32'hA5A5_0001;
        r1_we = 1; r1_byte = 0; r1_addr = 32'h24; r1_wdata = 32'h5A5A_0002;
        ref_wr(32'h20, 32'hA5A5_0001);
        ref_wr(32'h24, 32'h5A5A_0002);
        r0_req = 1; r1_req = 1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int n = 0; n < 10 && !got; n++) begin
                @(negedge clk);
                got = r0_gnt | r1_gnt;
            end
            chk("tie_gnt_seen", 64'(got), 64'd1);
`ifdef MEM_ARB_FIXED_PRIO_EN
            ek = 1'b0;
`else
            ek = (k % 2 == 1);
`endif
            if (got) begin
                chk("tie_order", 64'(r1_gnt), 64'(ek));
                if (k > 0) chk("tie_spacing", 64'(cyc - prev), 64'd3);
                prev = cyc;
            end
        end
        r0_req = 0; r1_req = 0;
        repeat (3) @(negedge clk);
        do_req(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, g);
        wait_drain();
        do_req(1'b0, 1'b0, 1'b0, 32'h24, 32'h0, g);
        wait_drain();

        // Reset in ACCESS of a read aborts it.
        do_req(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, g);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_m_we", 64'(m_we), 64'd0);
        chk("abort_gnt", 64'({r0_gnt, r1_gnt}), 64'd0);
        chk("abort_r0_rdata", 64'(r0_rdata), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            seen = seen | r0_rvalid | r1_rvalid;
        end
        chk("abort_no_rvalid", 64'(seen), 64'd0);
        start = cyc;
        do_req(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, g);
        chk("idle_after_rst", 64'(g - start), 64'd1);
        wait_drain();

        // Back-to-back: r1 raised during r0 ACCESS.
        do_req(1'b0, 1'b0, 1'b1, 32'h13, 32'h0, g0);
        do_req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, g1);
        chk("b2b_gap", 64'(g1 - g0), 64'd3);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 10, SHALL set the memory address width forwarded on m_addr.
REQ-002 Parameter DW, default 32, SHALL set the data width of all wdata/rdata buses.
REQ-003 clk  input  1  SHALL be the clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 r0_req, r1_req  input  1 each  SHALL be the access request from requester 0 (CPU) and requester 1 (DMA/debug).
REQ-006 r0_we, r1_we  input  1 each  SHALL select write (1) or read (0).
REQ-007 r0_byte, r1_byte  input  1 each  SHALL select byte read (1) or word read (0).
REQ-008 r0_addr, r1_addr  input  32 each  SHALL be the byte address; only [AW-1:0] is used.
REQ-009 r0_wdata, r1_wdata  input  DW each  SHALL be the write data.
REQ-010 r0_gnt, r1_gnt  output  1 each  SHALL be a one-cycle pulse: command accepted.
REQ-011 r0_rvalid, r1_rvalid  output  1 each  SHALL be a one-cycle pulse: rN_rdata valid.
REQ-012 r0_rdata, r1_rdata  output  DW each  SHALL be the read return data.
REQ-013 m_we  output  1  SHALL be the memory write enable.
REQ-014 m_byte  output  1  SHALL be the memory byte-load select.
REQ-015 m_addr  output  AW  SHALL be the memory byte address.
REQ-016 m_wdata  output  DW  SHALL be the memory write data.
REQ-017 m_rdata  input  DW  SHALL be the memory read data, valid before the posedge ending an access cycle (memory drives it on negedge).

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP; IDLE->ACCESS on any sampled request, ACCESS->RESP, RESP->IDLE unconditionally; one access per 3 cycles.
REQ-019 In IDLE at posedge with a request pending, the block SHALL latch the winner's we/byte/addr/wdata and pulse the winner's gnt in the following (ACCESS) cycle.
REQ-020 Ties (both req high) SHALL be resolved round-robin: the requester not served last wins; last-served SHALL reset to requester 1 so requester 0 wins the first tie.
REQ-021 A lone requester SHALL always win and SHALL update last-served.
REQ-022 In ACCESS, m_addr/m_wdata/m_byte SHALL drive the latched command and m_we SHALL equal the latched we; in IDLE and RESP m_we SHALL be 0, other m_* hold last values.
REQ-023 For writes m_byte SHALL be 0 regardless of rN_byte; byte writes are not supported.
REQ-024 For reads, m_rdata SHALL be registered at the posedge ending ACCESS into the winner's rdata; the winner's rvalid SHALL pulse for exactly the RESP cycle.
REQ-025 Writes SHALL produce no rvalid; rN_rdata SHALL hold its value until the next read for that requester.
REQ-026 Requests arriving in ACCESS/RESP SHALL be ignored until IDLE; a requester SHALL hold req and command stable until gnt, and req still high in the cycle after gnt SHALL count as a new request.
REQ-027 At most one gnt and at most one rvalid SHALL be high in any cycle.

Reset
REQ-028 rst low SHALL force state IDLE, all gnt/rvalid/m_we 0, all rdata/m_addr/m_wdata/m_byte 0, last-served = 1, asynchronously.
REQ-029 Reset during ACCESS or RESP SHALL abort the access; no rvalid SHALL follow after reset release.

Configuration
REQ-030 Macro MEM_ARB_FIXED_PRIO_EN defined: ties SHALL always go to requester 0 and last-served logic is removed; undefined: round-robin per REQ-020.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state enum (IDLE=0, ACCESS=1, RESP=2) and requester-ID constants REQ_CPU=0, REQ_DMA=1.
REQ-032 The tie-break SHALL be a sub-module rr_arb2 (2 requests, last-served in, winner out).

Verification
REQ-033 r0 write addr 0x10 data 0xDEADBEEF, then r0 word read 0x10 -> r0_gnt pulses, m_we=1 one cycle, later r0_rvalid with r0_rdata=0xDEADBEEF.
REQ-034 r1 byte read 0x11 after REQ-033 -> m_byte=1, r1_rdata=0x000000BE, r1_rvalid one cycle, r0 outputs unchanged.
REQ-035 Both req held high for 4 grants -> order r0,r1,r0,r1 (round-robin); with MEM_ARB_FIXED_PRIO_EN -> r0,r0,r0,r0.
REQ-036 rst low in ACCESS of a read -> no rvalid after release, state IDLE, m_we=0.
REQ-037 Back-to-back: r1 raises req during r0 ACCESS -> r1 granted only after RESP, 3 cycles after r0_gnt.
